nibble_packer: RTL and testbench

Upstream feed stage for the split-and-instance top level. Accepts a valid/ready stream of NIB_W-bit nibbles and packs consecutive pairs into one 2*NIB_W-bit word, which drives the top-level `pipelined_signals` input. A 2-entry output buffer decouples it from the consumer. An odd-length packet is closed by padding the low half.

---
 rtl/nibble_packer_pkg.sv | 26 ++
 rtl/nibble_packer_fifo2.sv | 63 ++++++
 rtl/nibble_packer.sv | 125 ++++++++++++
 tb/tb_nibble_packer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_pkg.sv
// Shared types for the nibble packer: pack FSM states and the word format
// carried through the output buffer.
package nibble_packer_pkg;

    localparam int DEF_NIB_W  = 4;
    localparam int DEF_WORD_W = 2 * DEF_NIB_W;

    // S_LO: no nibble held. S_HI: first (high) nibble sits in the hold register.
    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } pack_state_e;

    // Buffer entry at the default nibble width; the top declares the same
    // layout at its own NIB_W so non-default widths keep working.
    typedef struct packed {
        logic [DEF_WORD_W-1:0] data;
        logic                  last;
        logic                  padded;
    } packed_word_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/nibble_packer_fifo2.sv
// Generic two-entry register FIFO. Entry 0 is always the head, so the
// consumer sees a registered value with no read mux behind it.
module fifo2
    import nibble_packer_pkg::*;
#(
    parameter int  W = 10,
    parameter type T = logic [W-1:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  T           push_data,
    input  logic       pop,
    output T           head,
    output logic [1:0] occ,
    output logic       full,
    output logic       empty
);

    T           r_ent0;
    T           r_ent1;
    logic [1:0] r_occ;
    logic       w_do_push;
    logic       w_do_pop;

    assign w_do_push = push && (r_occ != OCC_FULL);
    assign w_do_pop  = pop  && (r_occ != OCC_EMPTY);

    assign head  = r_ent0;
    assign occ   = r_occ;
    assign full  = (r_occ == OCC_FULL);
    assign empty = (r_occ == OCC_EMPTY);

    // Shift-style storage: a pop moves entry 1 up, a push lands in the first free slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent0 <= T'('0);
            r_ent1 <= T'('0);
            r_occ  <= OCC_EMPTY;
        end else begin
            if (w_do_pop) begin
                if (r_occ == OCC_FULL) begin
                    r_ent0 <= r_ent1;
                end else if (w_do_push) begin
                    r_ent0 <= push_data;
                end
            end else if (w_do_push) begin
                if (r_occ == OCC_EMPTY) begin
                    r_ent0 <= push_data;
                end else begin
                    r_ent1 <= push_data;
                end
            end

            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// Packs pairs of nibbles into words behind a two-entry output buffer.
// An odd-length packet is closed by padding the low half with PAD_NIBBLE.
//
//   state | meaning
//   S_LO  | no nibble held; next accepted nibble is a high half
//   S_HI  | high nibble in r_hold; next accepted nibble completes the word
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int               NIB_W      = 4,
    parameter logic [NIB_W-1:0] PAD_NIBBLE = '0,
    parameter int               CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIB_W-1:0]     in_nibble,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*NIB_W-1:0]   out_data,
    output logic                 out_last,
    output logic                 out_padded,
    output logic [CNT_W-1:0]     word_count
);

    localparam int WORD_W = 2 * NIB_W;
    localparam int ENT_W  = WORD_W + 2;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
        logic              padded;
    } entry_t;

    pack_state_e      r_state;
    logic [NIB_W-1:0] r_hold;
    logic [CNT_W-1:0] r_word_count;

    logic             w_accept;
    logic             w_push;
    entry_t           w_push_ent;
    logic             w_pop;
    entry_t           w_head;
    logic [1:0]       w_occ;
    logic             w_full;
    logic             w_empty;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (w_occ != OCC_FULL);
    assign w_accept  = in_valid && !w_full;
    assign out_valid = !w_empty;
    assign w_pop     = !w_empty && out_ready;

    assign out_data   = w_head.data;
    assign out_last   = w_head.last;
    assign out_padded = w_head.padded;
    assign word_count = r_word_count;

    // Build the buffer entry when an accepted nibble completes a word.
    always_comb begin
        w_push     = 1'b0;
        w_push_ent = '0;
        if (w_accept) begin
            if (r_state == S_HI) begin
                w_push            = 1'b1;
                w_push_ent.data   = {r_hold, in_nibble};
                w_push_ent.last   = in_last;
                w_push_ent.padded = 1'b0;
            end else if (in_last) begin
                w_push            = 1'b1;
                w_push_ent.data   = {in_nibble, PAD_NIBBLE};
                w_push_ent.last   = 1'b1;
                w_push_ent.padded = 1'b1;
            end
        end
    end

    // Pack FSM and hold register; a held nibble waits indefinitely for its partner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LO;
            r_hold  <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_LO: begin
                    if (!in_last) begin
                        r_hold  <= in_nibble;
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    r_state <= S_LO;
                end
                default: r_state <= S_LO;
            endcase
        end
    end

    // Count of words handed to the consumer; wraps freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    fifo2 #(
        .W (ENT_W),
        .T (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_ent),
        .pop       (w_pop),
        .head      (w_head),
        .occ       (w_occ),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: directed scenarios then random traffic, all
// checked against a queue-based model of packets and buffered words.
module tb_nibble_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_nibble;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid, out_last, out_padded;
    logic [7:0] out_data;
    logic [15:0] word_count;

    logic       in_ready4, out_valid4, out_last4, out_padded4;
    logic [7:0] out_data4;
    logic [3:0] word_count4;

    always #5 clk = ~clk;

    nibble_packer #(.NIB_W(4), .PAD_NIBBLE(4'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_nibble(in_nibble), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_padded(out_padded), .word_count(word_count)
    );

    nibble_packer #(.NIB_W(4), .PAD_NIBBLE(4'h0), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4), .in_nibble(in_nibble), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_last(out_last4), .out_padded(out_padded4), .word_count(word_count4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: words waiting for the consumer as {data, last, padded}.
    logic [9:0]  mq[$];
    bit          have_hi = 1'b0;
    logic [3:0]  hi_nib  = 4'h0;
    int unsigned n_pops  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] exp_cnt;
        logic [3:0]  exp_cnt4;
        exp_cnt  = n_pops[15:0];
        exp_cnt4 = n_pops[3:0];
        chk("in_ready",   in_ready,  mq.size() < 2);
        chk("out_valid",  out_valid, mq.size() != 0);
        chk("in_ready4",  in_ready4, mq.size() < 2);
        chk("out_valid4", out_valid4, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_data",   out_data,   mq[0][9:2]);
            chk("out_last",   out_last,   mq[0][1]);
            chk("out_padded", out_padded, mq[0][0]);
            chk("out_data4",  out_data4,  mq[0][9:2]);
        end
        chk("word_count",  word_count,  exp_cnt);
        chk("word_count4", word_count4, exp_cnt4);
    endtask

    // Drive one cycle, advance the model across the edge, then check at the falling edge.
    task automatic step(input bit rst, input bit v, input logic [3:0] n, input bit l,
                        input bit ordy, output bit accepted);
        bit can_take;
        rst_n     = !rst;
        in_valid  = v;
        in_nibble = n;
        in_last   = l;
        out_ready = ordy;
        accepted  = 1'b0;
        if (rst) begin
            mq.delete();
            have_hi = 1'b0;
            hi_nib  = 4'h0;
            n_pops  = 0;
        end else begin
            can_take = (mq.size() < 2);
            if (ordy && mq.size() != 0) begin
                void'(mq.pop_front());
                n_pops++;
            end
            if (v && can_take) begin
                accepted = 1'b1;
                if (have_hi) begin
                    mq.push_back({hi_nib, n, l, 1'b0});
                    have_hi = 1'b0;
                end else if (l) begin
                    mq.push_back({n, 4'h0, 1'b1, 1'b1});
                end else begin
                    have_hi = 1'b1;
                    hi_nib  = n;
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit ordy, input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 4'h0, 1'b0, ordy, acc);
    endtask

    task automatic send(input logic [3:0] n, input bit l, input bit ordy);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            step(1'b0, 1'b1, n, l, ordy, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_dut();
        bit acc;
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, acc);
        chk("rst_out_valid",  out_valid,  1'b0);
        chk("rst_out_data",   out_data,   8'h00);
        chk("rst_out_last",   out_last,   1'b0);
        chk("rst_out_padded", out_padded, 1'b0);
        chk("rst_word_count", word_count, 16'd0);
        chk("rst_in_ready",   in_ready,   1'b1);
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; in_nibble = 4'h0; in_last = 1'b0; out_ready = 1'b0;
        reset_dut();
        reset_dut();

        // A5 pair, one word straight through.
        send(4'hA, 1'b0, 1'b1);
        send(4'h5, 1'b1, 1'b1);
        chk("a5_data", out_data, 8'hA5);
        idle(1'b1, 2);
        chk("a5_count", word_count, 16'd1);

        // Single-nibble padded packet.
        send(4'h7, 1'b1, 1'b1);
        chk("pad_data",   out_data,   8'h70);
        chk("pad_padded", out_padded, 1'b1);
        idle(1'b1, 2);

        // Back-pressure: two words fill the buffer, nibble 5 stalls.
        for (int i = 1; i <= 4; i++) send(4'(i), 1'b0, 1'b0);
        chk("bp_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, acc);
            chk("bp_stall", acc, 1'b0);
        end
        send(4'h5, 1'b0, 1'b1);
        send(4'h6, 1'b1, 1'b1);
        idle(1'b1, 4);

        // Full-rate stream of 16 nibbles.
        reset_dut();
        for (int i = 0; i < 16; i++) send(4'(i ^ 5), i == 15, 1'b1);
        idle(1'b1, 4);
        chk("stream_count", word_count, 16'd8);

        // Reset mid-packet drops the held nibble.
        reset_dut();
        send(4'h3, 1'b0, 1'b1);
        reset_dut();
        send(4'h9, 1'b0, 1'b1);
        send(4'hC, 1'b1, 1'b1);
        chk("rstmid_data", out_data, 8'h9C);
        idle(1'b1, 3);
        chk("rstmid_count", word_count, 16'd1);

        // 17 pops: the 4-bit counter wraps to 1.
        reset_dut();
        for (int i = 0; i < 34; i++) send(4'($urandom_range(0, 15)), 1'b0, 1'b1);
        idle(1'b1, 4);
        chk("wrap_count4", word_count4, 4'd1);
        chk("wrap_count",  word_count,  16'd17);

        // Random traffic with varying back-pressure and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            bit rst_now;
            rst_now = ($urandom_range(0, 299) == 0);
            step(rst_now, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0,
                 (i / 500) % 2 == 0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0),
                 acc);
        end
        idle(1'b1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
